fsgn_arb: RTL and testbench

- Shares one sign-injection datapath (fsgninj) between two requesters with round-robin arbitration and valid/ready handshakes.
  - Requester 0 is the FPU execute path: fsgnj, fsgnjn and fsgnjx.
  - Requester 1 is the integer-side fneg/fabs/fmv helper path.
- Registers the fsgninj result in a single output stage, tagged with the source requester and a destination tag.
- Sits in the FPU execute stage, between the operand muxes and the FPU result select.

---
 rtl/fsgn_arb_pkg.sv | 32 +++
 rtl/fsgninj.sv | 32 +++
 rtl/fsgn_arb.sv | 127 ++++++++++++
 tb/tb_fsgn_arb.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fsgn_arb_pkg.sv
// rtl/fsgn_arb_pkg.sv - core configuration type and sign-injection opcode constants
package fsgn_arb_pkg;

    // Floating-point configuration consumed by the sign-injection datapath.
    // FMT/FMT1 are the Fmt encodings of the full and first reduced precision.
    typedef struct packed {
        int FLEN;
        int FMTBITS;
        int FPSIZES;
        int LEN1;
        int LEN2;
        int FMT;
        int FMT1;
    } cvw_t;

    // Double + single: FLEN=64, single is the 32-bit reduced format.
    localparam cvw_t CVW_DEFAULT = '{
        FLEN:    64,
        FMTBITS: 1,
        FPSIZES: 2,
        LEN1:    32,
        LEN2:    16,
        FMT:     1,
        FMT1:    0
    };

    // OpCtrl encodings; 2'b11 is illegal.
    localparam logic [1:0] SGNJ  = 2'b00;
    localparam logic [1:0] SGNJN = 2'b01;
    localparam logic [1:0] SGNJX = 2'b10;

endpackage

// File: rtl/fsgninj.sv
// rtl/fsgninj.sv - sign injection with NaN-boxing of reduced formats
module fsgninj import fsgn_arb_pkg::*; #(
    parameter cvw_t P = CVW_DEFAULT
) (
    input  logic                 Xs,
    input  logic                 Ys,
    input  logic [P.FLEN-1:0]    X,
    input  logic [P.FMTBITS-1:0] Fmt,
    input  logic [1:0]           OpCtrl,
    output logic [P.FLEN-1:0]    SgnRes
);

    logic res_sgn;

    // fsgnj copies Ys, fsgnjn inverts it, fsgnjx xors it with Xs
    assign res_sgn = OpCtrl[1] ? (Xs ^ Ys) : (Ys ^ OpCtrl[0]);

    // Sign lands at the MSB of the selected format; bits above it are forced to 1
    if (P.FPSIZES == 1) begin : g_one
        assign SgnRes = {res_sgn, X[P.FLEN-2:0]};
    end else if (P.FPSIZES == 2) begin : g_two
        assign SgnRes = Fmt[0] ? {res_sgn, X[P.FLEN-2:0]}
                               : {{(P.FLEN-P.LEN1){1'b1}}, res_sgn, X[P.LEN1-2:0]};
    end else begin : g_three
        localparam logic [P.FMTBITS-1:0] FMT_FULL = P.FMT[P.FMTBITS-1:0];
        localparam logic [P.FMTBITS-1:0] FMT_LEN1 = P.FMT1[P.FMTBITS-1:0];
        assign SgnRes = (Fmt == FMT_FULL) ? {res_sgn, X[P.FLEN-2:0]}
                      : (Fmt == FMT_LEN1) ? {{(P.FLEN-P.LEN1){1'b1}}, res_sgn, X[P.LEN1-2:0]}
                      : {{(P.FLEN-P.LEN2){1'b1}}, res_sgn, X[P.LEN2-2:0]};
    end

endmodule

// File: rtl/fsgn_arb.sv
// rtl/fsgn_arb.sv - round-robin shared sign-injection unit with one registered output stage
module fsgn_arb import fsgn_arb_pkg::*; #(
    parameter cvw_t P    = CVW_DEFAULT,
    parameter int   TAGW = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 FlushE,

    input  logic                 Req0Valid,
    output logic                 Req0Ready,
    input  logic [P.FLEN-1:0]    Req0X,
    input  logic                 Req0Xs,
    input  logic                 Req0Ys,
    input  logic [P.FMTBITS-1:0] Req0Fmt,
    input  logic [1:0]           Req0OpCtrl,
    input  logic [TAGW-1:0]      Req0Tag,

    input  logic                 Req1Valid,
    output logic                 Req1Ready,
    input  logic [P.FLEN-1:0]    Req1X,
    input  logic                 Req1Xs,
    input  logic                 Req1Ys,
    input  logic [P.FMTBITS-1:0] Req1Fmt,
    input  logic [1:0]           Req1OpCtrl,
    input  logic [TAGW-1:0]      Req1Tag,

    output logic                 ResValid,
    input  logic                 ResReady,
    output logic [P.FLEN-1:0]    ResX,
    output logic [TAGW-1:0]      ResTag,
    output logic                 ResSrc
);

    logic                 res_valid_q, res_valid_d;
    logic [P.FLEN-1:0]    res_x_q,     res_x_d;
    logic [TAGW-1:0]      res_tag_q,   res_tag_d;
    logic                 res_src_q,   res_src_d;
    logic                 last_gnt_q,  last_gnt_d;

    logic                 slot_free;
    logic                 grant_ok;
    logic                 sel0, sel1;
    logic                 accept;

    logic [P.FLEN-1:0]    sel_x;
    logic                 sel_xs, sel_ys;
    logic [P.FMTBITS-1:0] sel_fmt;
    logic [1:0]           sel_op;
    logic [TAGW-1:0]      sel_tag;
    logic [P.FLEN-1:0]    sgn_res;

    // Slot can take a new result when empty or when the held one drains this cycle
    always_comb begin
        slot_free = ~res_valid_q | ResReady;
        grant_ok  = slot_free & ~FlushE & ~reset;
        // On a conflict the requester that did not win last time goes first
        sel0      = Req0Valid & (~Req1Valid | last_gnt_q);
        sel1      = Req1Valid & (~Req0Valid | ~last_gnt_q);
        Req0Ready = grant_ok & sel0;
        Req1Ready = grant_ok & sel1;
        accept    = Req0Ready | Req1Ready;
    end

    // Steer the selected requester's operands into the shared datapath
    always_comb begin
        sel_x   = sel1 ? Req1X      : Req0X;
        sel_xs  = sel1 ? Req1Xs     : Req0Xs;
        sel_ys  = sel1 ? Req1Ys     : Req0Ys;
        sel_fmt = sel1 ? Req1Fmt    : Req0Fmt;
        sel_op  = sel1 ? Req1OpCtrl : Req0OpCtrl;
        sel_tag = sel1 ? Req1Tag    : Req0Tag;
    end

    fsgninj #(.P(P)) u_fsgninj (
        .Xs     (sel_xs),
        .Ys     (sel_ys),
        .X      (sel_x),
        .Fmt    (sel_fmt),
        .OpCtrl (sel_op),
        .SgnRes (sgn_res)
    );

    // Output stage next state: load on accept, otherwise flush or drain empties it
    always_comb begin
        res_valid_d = res_valid_q;
        res_x_d     = res_x_q;
        res_tag_d   = res_tag_q;
        res_src_d   = res_src_q;
        last_gnt_d  = last_gnt_q;
        if (accept) begin
            res_valid_d = 1'b1;
            res_x_d     = sgn_res;
            res_tag_d   = sel_tag;
            res_src_d   = sel1;
            last_gnt_d  = sel1;
        end else if (FlushE | ResReady) begin
            res_valid_d = 1'b0;
        end
    end

    // Output stage and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid_q <= 1'b0;
            res_x_q     <= '0;
            res_tag_q   <= '0;
            res_src_q   <= 1'b0;
            last_gnt_q  <= 1'b1;
        end else begin
            res_valid_q <= res_valid_d;
            res_x_q     <= res_x_d;
            res_tag_q   <= res_tag_d;
            res_src_q   <= res_src_d;
            last_gnt_q  <= last_gnt_d;
        end
    end

    assign ResValid = res_valid_q;
    assign ResX     = res_x_q;
    assign ResTag   = res_tag_q;
    assign ResSrc   = res_src_q;

    a_no_illegal_op: assert property (@(posedge clk) disable iff (reset)
        accept |-> (sel_op != 2'b11));

endmodule

// File: tb/tb_fsgn_arb.sv
// tb/tb_fsgn_arb.sv - self-checking bench for fsgn_arb
module tb_fsgn_arb;
    import fsgn_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        FlushE;
    logic        Req0Valid, Req0Ready, Req0Xs, Req0Ys;
    logic [63:0] Req0X;
    logic [0:0]  Req0Fmt;
    logic [1:0]  Req0OpCtrl;
    logic [4:0]  Req0Tag;
    logic        Req1Valid, Req1Ready, Req1Xs, Req1Ys;
    logic [63:0] Req1X;
    logic [0:0]  Req1Fmt;
    logic [1:0]  Req1OpCtrl;
    logic [4:0]  Req1Tag;
    logic        ResValid, ResReady, ResSrc;
    logic [63:0] ResX;
    logic [4:0]  ResTag;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fsgn_arb #(.P(CVW_DEFAULT), .TAGW(5)) dut (
        .clk(clk), .reset(reset), .FlushE(FlushE),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0X(Req0X), .Req0Xs(Req0Xs),
        .Req0Ys(Req0Ys), .Req0Fmt(Req0Fmt), .Req0OpCtrl(Req0OpCtrl), .Req0Tag(Req0Tag),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1X(Req1X), .Req1Xs(Req1Xs),
        .Req1Ys(Req1Ys), .Req1Fmt(Req1Fmt), .Req1OpCtrl(Req1OpCtrl), .Req1Tag(Req1Tag),
        .ResValid(ResValid), .ResReady(ResReady), .ResX(ResX), .ResTag(ResTag), .ResSrc(ResSrc)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sign injection from the instruction definitions: pick the new sign, put it
    // at the format MSB, NaN-box a single-precision result.
    function automatic logic [63:0] inject(input logic [63:0] x, input logic xs, input logic ys,
                                           input logic fmt, input logic [1:0] op);
        logic s;
        case (op)
            2'b00:   s = ys;
            2'b01:   s = ~ys;
            default: s = xs ^ ys;
        endcase
        if (fmt) return {s, x[62:0]};
        return {32'hFFFF_FFFF, s, x[30:0]};
    endfunction

    // Reference model state: what the output stage must hold after the next edge
    bit          m_init = 0;
    logic        m_valid, m_src, m_last;
    logic [63:0] m_x;
    logic [4:0]  m_tag;

    always @(negedge clk) begin
        logic free, ok, win, e0, e1;
        free = !m_valid || ResReady;
        ok   = free && !FlushE && !reset;
        if (Req0Valid && Req1Valid) win = !m_last;
        else                        win = Req1Valid;
        e0 = ok && Req0Valid && (win == 1'b0);
        e1 = ok && Req1Valid && (win == 1'b1);
        if (m_init) begin
            check("model Req0Ready", {63'd0, Req0Ready}, {63'd0, e0});
            check("model Req1Ready", {63'd0, Req1Ready}, {63'd0, e1});
            check("model ResValid",  {63'd0, ResValid},  {63'd0, m_valid});
            check("model ResX",      ResX, m_x);
            check("model ResTag",    {59'd0, ResTag},    {59'd0, m_tag});
            check("model ResSrc",    {63'd0, ResSrc},    {63'd0, m_src});
        end
        if (reset) begin
            m_init  = 1;
            m_valid = 0; m_x = '0; m_tag = '0; m_src = 0; m_last = 1;
        end else if (m_init) begin
            if (e0 || e1) begin
                m_valid = 1;
                m_src   = e1;
                m_last  = e1;
                m_x     = e1 ? inject(Req1X, Req1Xs, Req1Ys, Req1Fmt[0], Req1OpCtrl)
                             : inject(Req0X, Req0Xs, Req0Ys, Req0Fmt[0], Req0OpCtrl);
                m_tag   = e1 ? Req1Tag : Req0Tag;
            end else if (FlushE || ResReady) begin
                m_valid = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        reset = 1; FlushE = 0; ResReady = 1;
        Req0Valid = 0; Req0X = '0; Req0Xs = 0; Req0Ys = 0; Req0Fmt = 0; Req0OpCtrl = 0; Req0Tag = 0;
        Req1Valid = 0; Req1X = '0; Req1Xs = 0; Req1Ys = 0; Req1Fmt = 0; Req1OpCtrl = 0; Req1Tag = 0;
        step(); step();
        reset = 0;
        neg();
        check("reset ResValid", {63'd0, ResValid}, 64'd0);
        check("reset ResX", ResX, 64'd0);

        // 1: requester 0 alone, fsgnjn double
        step();
        Req0Valid = 1; Req0Fmt = 1; Req0OpCtrl = SGNJN; Req0X = 64'h3FF0_0000_0000_0000;
        Req0Xs = 0; Req0Ys = 0; Req0Tag = 5'd3;
        neg();
        check("t1 Req0Ready", {63'd0, Req0Ready}, 64'd1);
        step();
        Req0Valid = 0;
        neg();
        check("t1 ResValid", {63'd0, ResValid}, 64'd1);
        check("t1 ResX", ResX, 64'hBFF0_0000_0000_0000);
        check("t1 ResTag", {59'd0, ResTag}, 64'd3);
        check("t1 ResSrc", {63'd0, ResSrc}, 64'd0);

        // 2: requester 1 alone, fsgnjx single
        step();
        Req1Valid = 1; Req1Fmt = 0; Req1OpCtrl = SGNJX; Req1X = 64'hFFFF_FFFF_3F80_0000;
        Req1Xs = 0; Req1Ys = 1; Req1Tag = 5'd7;
        neg();
        check("t2 Req1Ready", {63'd0, Req1Ready}, 64'd1);
        step();
        Req1Valid = 0;
        neg();
        check("t2 ResX", ResX, 64'hFFFF_FFFF_BF80_0000);
        check("t2 ResSrc", {63'd0, ResSrc}, 64'd1);
        check("t2 ResTag", {59'd0, ResTag}, 64'd7);

        // 3: both valid, full throughput, grants alternate
        step();
        Req0Valid = 1; Req0Fmt = 1; Req0OpCtrl = SGNJ; Req0X = 64'h4000_0000_0000_0000;
        Req0Xs = 0; Req0Ys = 1; Req0Tag = 5'd10;
        Req1Valid = 1; Req1Fmt = 0; Req1OpCtrl = SGNJN; Req1X = 64'hFFFF_FFFF_4040_0000;
        Req1Xs = 0; Req1Ys = 0; Req1Tag = 5'd20;
        for (int i = 0; i < 4; i++) begin
            neg();
            check("t3 Req0Ready", {63'd0, Req0Ready}, (i % 2 == 0) ? 64'd1 : 64'd0);
            check("t3 Req1Ready", {63'd0, Req1Ready}, (i % 2 == 1) ? 64'd1 : 64'd0);
            if (i > 0) begin
                check("t3 ResValid", {63'd0, ResValid}, 64'd1);
                check("t3 ResSrc", {63'd0, ResSrc}, ((i - 1) % 2 == 1) ? 64'd1 : 64'd0);
                check("t3 ResTag", {59'd0, ResTag}, ((i - 1) % 2 == 1) ? 64'd20 : 64'd10);
            end
            step();
        end

        // 4: held result blocks both requesters, then drain and refill together
        ResReady = 0;
        for (int j = 0; j < 3; j++) begin
            neg();
            check("t4 hold Req0Ready", {63'd0, Req0Ready}, 64'd0);
            check("t4 hold Req1Ready", {63'd0, Req1Ready}, 64'd0);
            check("t4 hold ResX", ResX, 64'hFFFF_FFFF_C040_0000);
            check("t4 hold ResSrc", {63'd0, ResSrc}, 64'd1);
            step();
        end
        ResReady = 1;
        neg();
        check("t4 refill Req0Ready", {63'd0, Req0Ready}, 64'd1);
        check("t4 refill Req1Ready", {63'd0, Req1Ready}, 64'd0);
        step();
        Req0Valid = 0; Req1Valid = 0;
        neg();
        check("t4 ResValid", {63'd0, ResValid}, 64'd1);
        check("t4 ResSrc", {63'd0, ResSrc}, 64'd0);
        check("t4 ResX", ResX, 64'hC000_0000_0000_0000);
        step();
        neg();
        check("t4 drained ResValid", {63'd0, ResValid}, 64'd0);

        // 5: flush discards held result and blocks accept for one cycle
        step();
        ResReady = 0;
        Req0Valid = 1; Req0Fmt = 1; Req0OpCtrl = SGNJN; Req0X = 64'h3FF0_0000_0000_0000;
        Req0Xs = 0; Req0Ys = 0; Req0Tag = 5'd5;
        neg();
        check("t5 Req0Ready", {63'd0, Req0Ready}, 64'd1);
        step();
        Req0Tag = 5'd6; FlushE = 1;
        neg();
        check("t5 flush ResValid", {63'd0, ResValid}, 64'd1);
        check("t5 flush Req0Ready", {63'd0, Req0Ready}, 64'd0);
        step();
        FlushE = 0;
        neg();
        check("t5 post ResValid", {63'd0, ResValid}, 64'd0);
        check("t5 retry Req0Ready", {63'd0, Req0Ready}, 64'd1);
        step();
        Req0Valid = 0;
        neg();
        check("t5 ResTag", {59'd0, ResTag}, 64'd6);
        check("t5 ResValid", {63'd0, ResValid}, 64'd1);

        // 6: reset while holding, then requester 0 wins the first conflict
        step();
        Req0Valid = 1; Req1Valid = 1; reset = 1;
        neg();
        check("t6 reset Req0Ready", {63'd0, Req0Ready}, 64'd0);
        check("t6 reset Req1Ready", {63'd0, Req1Ready}, 64'd0);
        step();
        neg();
        check("t6 ResValid", {63'd0, ResValid}, 64'd0);
        check("t6 in reset Req1Ready", {63'd0, Req1Ready}, 64'd0);
        step();
        reset = 0;
        neg();
        check("t6 Req0Ready", {63'd0, Req0Ready}, 64'd1);
        check("t6 Req1Ready", {63'd0, Req1Ready}, 64'd0);
        step();
        Req0Valid = 0; Req1Valid = 0;
        neg();
        check("t6 ResSrc", {63'd0, ResSrc}, 64'd0);
        check("t6 ResValid", {63'd0, ResValid}, 64'd1);
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
